tt_vector_checker: RTL and testbench

Parametrised stimulus/response checker for the tile-level bench. It buffers up to DEPTH test vectors from the cocotb bench, applies them to the user project's ui_in one per clock, and compares uo_out against masked expected values after a fixed pipeline latency. It reports an error count and the index of the first failing vector. It generalises the plain bench wrapper into a self-checking harness with configurable width, depth and DUT latency.

---
 rtl/tt_vector_checker_if.sv | 57 +++++
 rtl/tt_vector_checker.sv | 198 +++++++++++++++++++
 tb/tb_tt_vector_checker.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/tt_vector_checker_if.sv
// Vector/result bundle between the tile bench and tt_vector_checker.
// TT_VCHK_UIO_EN adds the bidirectional uio fields and DUT pins.
interface tt_vector_checker_if #(
   parameter int IN_W  = 8,
   parameter int OUT_W = 8,
   parameter int DEPTH = 16,
   parameter int CNT_W = 8
);
   localparam int IDX_W = $clog2(DEPTH) + 1;

   logic             vec_valid;
   logic             vec_ready;
   logic [IN_W-1:0]  vec_stim;
   logic [OUT_W-1:0] vec_exp;
   logic [OUT_W-1:0] vec_mask;
   logic             start;
   logic [IN_W-1:0]  dut_ui_in;
   logic [OUT_W-1:0] dut_uo_out;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] err_count;
   logic             first_err_valid;
   logic [IDX_W-1:0] first_err_idx;

`ifdef TT_VCHK_UIO_EN
   logic [7:0] vec_uio_stim;
   logic [7:0] vec_uio_exp;
   logic [7:0] vec_uio_mask;
   logic [7:0] dut_uio_in;
   logic [7:0] dut_uio_out;
   logic [7:0] dut_uio_oe;

   modport slave (
      input  vec_valid, vec_stim, vec_exp, vec_mask, start, dut_uo_out,
             vec_uio_stim, vec_uio_exp, vec_uio_mask, dut_uio_out, dut_uio_oe,
      output vec_ready, dut_ui_in, busy, done, err_count, first_err_valid,
             first_err_idx, dut_uio_in
   );
   modport master (
      output vec_valid, vec_stim, vec_exp, vec_mask, start, dut_uo_out,
             vec_uio_stim, vec_uio_exp, vec_uio_mask, dut_uio_out, dut_uio_oe,
      input  vec_ready, dut_ui_in, busy, done, err_count, first_err_valid,
             first_err_idx, dut_uio_in
   );
`else
   modport slave (
      input  vec_valid, vec_stim, vec_exp, vec_mask, start, dut_uo_out,
      output vec_ready, dut_ui_in, busy, done, err_count, first_err_valid,
             first_err_idx
   );
   modport master (
      output vec_valid, vec_stim, vec_exp, vec_mask, start, dut_uo_out,
      input  vec_ready, dut_ui_in, busy, done, err_count, first_err_valid,
             first_err_idx
   );
`endif
endinterface

// File: rtl/tt_vector_checker.sv
// Buffers stimulus/expected vectors, plays them into the DUT one per clock and
// counts masked mismatches LATENCY cycles later. Optional uio path: TT_VCHK_UIO_EN.
module tt_vector_checker #(
   parameter int IN_W    = 8,
   parameter int OUT_W   = 8,
   parameter int DEPTH   = 16,
   parameter int LATENCY = 2,
   parameter int CNT_W   = 8
) (
   input  logic               clk,
   input  logic               rst,
   tt_vector_checker_if.slave vif
);
   localparam int AW    = $clog2(DEPTH);
   localparam int IDX_W = AW + 1;
   localparam int DW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t           r_state;
   logic             r_busy;
   logic             r_done;
   logic [IN_W-1:0]  r_dut_ui_in;
   logic [CNT_W-1:0] r_err_count;
   logic             r_first_err_valid;
   logic [IDX_W-1:0] r_first_err_idx;
   logic [IDX_W-1:0] r_wr_ptr;
   logic [IDX_W-1:0] r_rd_ptr;
   logic [IDX_W-1:0] r_vec_idx;
   logic [DW-1:0]    r_drain_cnt;

   logic [IN_W-1:0]  r_fifo_stim [DEPTH];
   logic [OUT_W-1:0] r_fifo_exp  [DEPTH];
   logic [OUT_W-1:0] r_fifo_mask [DEPTH];

   logic [LATENCY:1] r_vld_pipe;
   logic [OUT_W-1:0] r_p_exp  [1:LATENCY];
   logic [OUT_W-1:0] r_p_mask [1:LATENCY];
   logic [IDX_W-1:0] r_p_idx  [1:LATENCY];

`ifdef TT_VCHK_UIO_EN
   logic [7:0] r_fifo_uio_stim [DEPTH];
   logic [7:0] r_fifo_uio_exp  [DEPTH];
   logic [7:0] r_fifo_uio_mask [DEPTH];
   logic [7:0] r_p_uio_exp  [1:LATENCY];
   logic [7:0] r_p_uio_mask [1:LATENCY];
   logic [7:0] r_dut_uio_in;
   logic       w_mis_uio;
`endif

   logic [IDX_W-1:0] w_count;
   logic [AW-1:0]    w_rd_addr;
   logic             w_full, w_empty, w_wr, w_pop, w_last, w_mis_uo, w_mis;

   assign w_count   = r_wr_ptr - r_rd_ptr;
   assign w_full    = (w_count == IDX_W'(DEPTH));
   assign w_empty   = (r_wr_ptr == r_rd_ptr);
   assign w_rd_addr = r_rd_ptr[AW-1:0];
   assign w_wr      = vif.vec_valid & vif.vec_ready;
   assign w_pop     = (r_state == S_RUN) & ~w_empty;
   assign w_last    = w_pop & (w_count == IDX_W'(1));

   assign w_mis_uo  = |((vif.dut_uo_out ^ r_p_exp[LATENCY]) & r_p_mask[LATENCY]);
`ifdef TT_VCHK_UIO_EN
   // Undriven uio pins are never checked, whatever the mask says.
   assign w_mis_uio = |((vif.dut_uio_out ^ r_p_uio_exp[LATENCY]) &
                        r_p_uio_mask[LATENCY] & vif.dut_uio_oe);
   assign w_mis     = r_vld_pipe[LATENCY] & (w_mis_uo | w_mis_uio);
   assign vif.dut_uio_in = r_dut_uio_in;
`else
   assign w_mis     = r_vld_pipe[LATENCY] & w_mis_uo;
`endif

   assign vif.vec_ready       = (r_state == S_IDLE) & ~w_full;
   assign vif.dut_ui_in       = r_dut_ui_in;
   assign vif.busy            = r_busy;
   assign vif.done            = r_done;
   assign vif.err_count       = r_err_count;
   assign vif.first_err_valid = r_first_err_valid;
   assign vif.first_err_idx   = r_first_err_idx;

   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_fifo_stim[r_wr_ptr[AW-1:0]] <= vif.vec_stim;
         r_fifo_exp[r_wr_ptr[AW-1:0]]  <= vif.vec_exp;
         r_fifo_mask[r_wr_ptr[AW-1:0]] <= vif.vec_mask;
`ifdef TT_VCHK_UIO_EN
         r_fifo_uio_stim[r_wr_ptr[AW-1:0]] <= vif.vec_uio_stim;
         r_fifo_uio_exp[r_wr_ptr[AW-1:0]]  <= vif.vec_uio_exp;
         r_fifo_uio_mask[r_wr_ptr[AW-1:0]] <= vif.vec_uio_mask;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state           <= S_IDLE;
         r_busy            <= 1'b0;
         r_done            <= 1'b0;
         r_dut_ui_in       <= '0;
         r_err_count       <= '0;
         r_first_err_valid <= 1'b0;
         r_first_err_idx   <= '0;
         r_wr_ptr          <= '0;
         r_rd_ptr          <= '0;
         r_vec_idx         <= '0;
         r_drain_cnt       <= '0;
         r_vld_pipe        <= '0;
         for (int k = 1; k <= LATENCY; k++) begin
            r_p_exp[k]  <= '0;
            r_p_mask[k] <= '0;
            r_p_idx[k]  <= '0;
`ifdef TT_VCHK_UIO_EN
            r_p_uio_exp[k]  <= '0;
            r_p_uio_mask[k] <= '0;
`endif
         end
`ifdef TT_VCHK_UIO_EN
         r_dut_uio_in <= '0;
`endif
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;

         // Stage k holds the vector popped k cycles ago; compare at stage LATENCY.
         r_vld_pipe[1] <= w_pop;
         r_p_exp[1]    <= r_fifo_exp[w_rd_addr];
         r_p_mask[1]   <= r_fifo_mask[w_rd_addr];
         r_p_idx[1]    <= r_vec_idx;
`ifdef TT_VCHK_UIO_EN
         r_p_uio_exp[1]  <= r_fifo_uio_exp[w_rd_addr];
         r_p_uio_mask[1] <= r_fifo_uio_mask[w_rd_addr];
`endif
         for (int k = 2; k <= LATENCY; k++) begin
            r_vld_pipe[k] <= r_vld_pipe[k-1];
            r_p_exp[k]    <= r_p_exp[k-1];
            r_p_mask[k]   <= r_p_mask[k-1];
            r_p_idx[k]    <= r_p_idx[k-1];
`ifdef TT_VCHK_UIO_EN
            r_p_uio_exp[k]  <= r_p_uio_exp[k-1];
            r_p_uio_mask[k] <= r_p_uio_mask[k-1];
`endif
         end

         if (w_mis) begin
            if (r_err_count != '1) r_err_count <= r_err_count + 1'b1;
            if (!r_first_err_valid) begin
               r_first_err_valid <= 1'b1;
               r_first_err_idx   <= r_p_idx[LATENCY];
            end
         end

         case (r_state)
            S_IDLE: if (vif.start) begin
               r_err_count       <= '0;
               r_first_err_valid <= 1'b0;
               r_first_err_idx   <= '0;
               r_vec_idx         <= '0;
               // A vector written on the start cycle still counts as queued.
               if (w_empty && !w_wr) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end else begin
                  r_state <= S_RUN;
                  r_busy  <= 1'b1;
               end
            end
            S_RUN: begin
               if (w_pop) begin
                  r_dut_ui_in <= r_fifo_stim[w_rd_addr];
`ifdef TT_VCHK_UIO_EN
                  r_dut_uio_in <= r_fifo_uio_stim[w_rd_addr];
`endif
                  r_rd_ptr  <= r_rd_ptr + 1'b1;
                  r_vec_idx <= r_vec_idx + 1'b1;
               end
               if (w_last || w_empty) begin
                  r_state     <= S_DRAIN;
                  r_drain_cnt <= DW'(LATENCY - 1);
               end
            end
            S_DRAIN: begin
               if (r_drain_cnt == '0) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_drain_cnt <= r_drain_cnt - 1'b1;
               end
            end
            S_DONE: if (vif.start) begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_tt_vector_checker.sv
// Directed bench for tt_vector_checker: a one-flop loopback stands in for the
// user project, giving a LATENCY=2 round trip from dut_ui_in back to the checker.
module tb_tt_vector_checker;
   localparam int LAT = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   tt_vector_checker_if #(.IN_W(8), .OUT_W(8), .DEPTH(16), .CNT_W(8)) vif ();
   tt_vector_checker_if #(.IN_W(8), .OUT_W(8), .DEPTH(8),  .CNT_W(2)) sif ();

   tt_vector_checker #(.IN_W(8), .OUT_W(8), .DEPTH(16), .LATENCY(LAT), .CNT_W(8))
      u_dut (.clk(clk), .rst(rst), .vif(vif.slave));
   tt_vector_checker #(.IN_W(8), .OUT_W(8), .DEPTH(8), .LATENCY(LAT), .CNT_W(2))
      u_sat (.clk(clk), .rst(rst), .vif(sif.slave));

   always_ff @(posedge clk) begin
      vif.dut_uo_out <= vif.dut_ui_in;
      sif.dut_uo_out <= sif.dut_ui_in;
   end

`ifdef TT_VCHK_UIO_EN
   initial begin
      vif.vec_uio_stim = '0; vif.vec_uio_exp = '0; vif.vec_uio_mask = '0;
      vif.dut_uio_out  = '0; vif.dut_uio_oe  = '0;
      sif.vec_uio_stim = '0; sif.vec_uio_exp = '0; sif.vec_uio_mask = '0;
      sif.dut_uio_out  = '0; sif.dut_uio_oe  = '0;
   end
`endif

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
      end
   endtask

   task automatic push(input logic [7:0] s, input logic [7:0] e, input logic [7:0] m);
      vif.vec_valid = 1'b1;
      vif.vec_stim  = s;
      vif.vec_exp   = e;
      vif.vec_mask  = m;
      @(posedge clk); #1;
      vif.vec_valid = 1'b0;
   endtask

   // Pulses start (optionally with a same-cycle vector) and checks done timing.
   task automatic run(input string tag, input int n, input bit wv,
                      input logic [7:0] s, input logic [7:0] e, input logic [7:0] m);
      int cnt;
      vif.start = 1'b1;
      if (wv) begin
         vif.vec_valid = 1'b1;
         vif.vec_stim  = s;
         vif.vec_exp   = e;
         vif.vec_mask  = m;
      end
      @(posedge clk); #1;
      vif.start     = 1'b0;
      vif.vec_valid = 1'b0;
      chk({tag, "_busy"}, 32'(vif.busy), 32'(n > 0));
      cnt = 0;
      while (!vif.done && cnt < 200) begin
         @(posedge clk); #1;
         cnt++;
      end
      chk({tag, "_done_lat"}, 32'(cnt), 32'((n > 0) ? n + LAT : 0));
      chk({tag, "_busy_end"}, 32'(vif.busy), 32'd0);
   endtask

   task automatic to_idle();
      vif.start = 1'b1;
      @(posedge clk); #1;
      vif.start = 1'b0;
      chk("to_idle_done", 32'(vif.done), 32'd0);
   endtask

   initial begin
      int cnt;
      vif.vec_valid = 0; vif.vec_stim = 0; vif.vec_exp = 0; vif.vec_mask = 0; vif.start = 0;
      sif.vec_valid = 0; sif.vec_stim = 0; sif.vec_exp = 0; sif.vec_mask = 0; sif.start = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      chk("rst_busy",  32'(vif.busy), 0);
      chk("rst_done",  32'(vif.done), 0);
      chk("rst_ui",    32'(vif.dut_ui_in), 0);
      chk("rst_err",   32'(vif.err_count), 0);
      chk("rst_fev",   32'(vif.first_err_valid), 0);
      chk("rst_fei",   32'(vif.first_err_idx), 0);
      chk("rst_ready", 32'(vif.vec_ready), 1);

      // all match through the loopback
      push(8'h11, 8'h11, 8'hFF); push(8'h22, 8'h22, 8'hFF);
      push(8'h33, 8'h33, 8'hFF); push(8'h44, 8'h44, 8'hFF);
      run("match", 4, 0, 0, 0, 0);
      chk("match_done", 32'(vif.done), 1);
      chk("match_err",  32'(vif.err_count), 0);
      chk("match_fev",  32'(vif.first_err_valid), 0);
      chk("match_ui",   32'(vif.dut_ui_in), 32'h44);
      to_idle();
      chk("idle_ui_hold", 32'(vif.dut_ui_in), 32'h44);

      // vector 2: DUT returns 0xAB, expected 0xAA
      push(8'h01, 8'h01, 8'hFF); push(8'h02, 8'h02, 8'hFF); push(8'hAB, 8'hAA, 8'hFF);
      push(8'h04, 8'h04, 8'hFF); push(8'h05, 8'h05, 8'hFF);
      run("ferr", 5, 0, 0, 0, 0);
      chk("ferr_err", 32'(vif.err_count), 1);
      chk("ferr_fev", 32'(vif.first_err_valid), 1);
      chk("ferr_fei", 32'(vif.first_err_idx), 2);
      to_idle();
      chk("idle_keep_err", 32'(vif.err_count), 1);

      // same mismatch masked off, plus a mask=0 vector that is totally wrong
      push(8'h01, 8'h01, 8'hFF); push(8'h02, 8'h02, 8'hFF); push(8'hAB, 8'hAA, 8'hFE);
      push(8'h04, 8'h04, 8'hFF); push(8'h05, 8'h05, 8'hFF); push(8'h0F, 8'hF0, 8'h00);
      run("mask", 6, 0, 0, 0, 0);
      chk("mask_err", 32'(vif.err_count), 0);
      chk("mask_fev", 32'(vif.first_err_valid), 0);
      to_idle();

      // two errors: only the first index is recorded
      push(8'h10, 8'h10, 8'hFF); push(8'h11, 8'h01, 8'hFF); push(8'h12, 8'h12, 8'hFF);
      push(8'h13, 8'h13, 8'hFF); push(8'h14, 8'h04, 8'h10);
      run("two", 5, 0, 0, 0, 0);
      chk("two_err", 32'(vif.err_count), 2);
      chk("two_fei", 32'(vif.first_err_idx), 1);
      to_idle();

      // fill FIFO, offer one extra, then play it all back
      for (int i = 0; i < 16; i++) begin
         chk("full_ready_pre", 32'(vif.vec_ready), 1);
         push(8'(i), (i == 9) ? 8'(i ^ 1) : 8'(i), 8'hFF);
      end
      chk("full_ready", 32'(vif.vec_ready), 0);
      push(8'hEE, 8'hEE, 8'hFF);
      chk("full_ready_hold", 32'(vif.vec_ready), 0);
      run("full", 16, 0, 0, 0, 0);
      chk("full_err", 32'(vif.err_count), 1);
      chk("full_fei", 32'(vif.first_err_idx), 9);
      chk("full_ui",  32'(vif.dut_ui_in), 32'h0F);
      to_idle();

      // empty start
      run("empty", 0, 0, 0, 0, 0);
      chk("empty_done", 32'(vif.done), 1);
      chk("empty_err",  32'(vif.err_count), 0);
      chk("empty_fev",  32'(vif.first_err_valid), 0);
      to_idle();

      // vector written in the start cycle joins the run
      run("same", 1, 1, 8'h5A, 8'h5B, 8'hFF);
      chk("same_err", 32'(vif.err_count), 1);
      chk("same_fei", 32'(vif.first_err_idx), 0);
      chk("same_ui",  32'(vif.dut_ui_in), 32'h5A);
      to_idle();

      // saturation: CNT_W=2, six failing vectors
      for (int i = 0; i < 6; i++) begin
         sif.vec_valid = 1'b1; sif.vec_stim = 8'(i); sif.vec_exp = ~8'(i); sif.vec_mask = 8'hFF;
         @(posedge clk); #1;
      end
      sif.vec_valid = 1'b0;
      sif.start = 1'b1;
      @(posedge clk); #1;
      sif.start = 1'b0;
      cnt = 0;
      while (!sif.done && cnt < 200) begin
         @(posedge clk); #1;
         cnt++;
      end
      chk("sat_done_lat", 32'(cnt), 32'(6 + LAT));
      chk("sat_err", 32'(sif.err_count), 3);
      chk("sat_fev", 32'(sif.first_err_valid), 1);
      chk("sat_fei", 32'(sif.first_err_idx), 0);

      // reset in RUN cycle 3
      for (int i = 0; i < 8; i++) push(8'(8'h81 + i), 8'h00, 8'hFF);
      vif.start = 1'b1;
      @(posedge clk); #1;
      vif.start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("mid_busy_pre", 32'(vif.busy), 1);
      chk("mid_ui_pre",   32'(vif.dut_ui_in), 32'h82);
      rst = 1'b1;
      #1;
      chk("mid_busy",  32'(vif.busy), 0);
      chk("mid_ui",    32'(vif.dut_ui_in), 0);
      chk("mid_err",   32'(vif.err_count), 0);
      chk("mid_ready", 32'(vif.vec_ready), 1);
      @(posedge clk); #1;
      rst = 1'b0;
      run("post_rst", 0, 0, 0, 0, 0);
      chk("post_rst_err", 32'(vif.err_count), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
